// File: rtl/data_pkg.sv
// Shared datapath types for the cell configuration table and CPU bus strobe decoding.
package data_pkg;

   // System default number of cell configuration entries.
   localparam int NUM_CFG = 256;

   typedef struct packed {
      logic [3:0]  FWD;
      logic [11:0] VPI;
   } CellCfgType;

   typedef struct packed {
      logic valid;
      logic write;
   } bus_req_t;

   // BusMode=1 uses separate active-low read/write strobes, so both low at once
   // is ambiguous and treated as no request. BusMode=0 uses a data strobe with
   // a read/not-write direction line.
   function automatic bus_req_t decode_req(input logic bus_mode,
                                           input logic sel,
                                           input logic rd_ds,
                                           input logic wr_rw);
      bus_req_t r;
      r = '0;
      if (!sel) begin
         if (bus_mode) begin
            r.valid = rd_ds ^ wr_rw;
            r.write = !wr_rw;
         end else begin
            r.valid = !rd_ds;
            r.write = !wr_rw;
         end
      end
      return r;
   endfunction

   // True while the strobe that started the current cycle is still asserted.
   // In BusMode=1 a write is held by Wr_RW; every other case by Rd_DS.
   function automatic logic strobe_held(input logic bus_mode,
                                        input logic write,
                                        input logic sel,
                                        input logic rd_ds,
                                        input logic wr_rw);
      logic held;
      held = 1'b0;
      if (!sel) begin
         if (bus_mode && write) held = !wr_rw;
         else                   held = !rd_ds;
      end
      return held;
   endfunction

endpackage

// File: rtl/cpu_if.sv
// CPU bus bundle shared by the configuration block and its host.
interface CPU_if;
   import data_pkg::*;

   logic        BusMode;
   logic [11:0] Addr;
   logic        Sel;
   CellCfgType  DataIn;
   logic        Rd_DS;
   logic        Wr_RW;
   CellCfgType  DataOut;
   logic        Rdy_Dtack;

   modport Peripheral (
      input  BusMode, Addr, Sel, DataIn, Rd_DS, Wr_RW,
      output DataOut, Rdy_Dtack
   );

   modport Host (
      output BusMode, Addr, Sel, DataIn, Rd_DS, Wr_RW,
      input  DataOut, Rdy_Dtack
   );

endinterface

// File: rtl/cpu_cfg_regs_mem.sv
// Configuration entry storage: one write port, registered CPU and lookup read ports.
module cfg_mem
   import data_pkg::*;
#(
   parameter int DEPTH = NUM_CFG,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  CellCfgType    wdata,
   input  logic          cpu_re,
   input  logic [AW-1:0] cpu_raddr,
   output CellCfgType    cpu_rdata,
   input  logic [AW-1:0] lut_raddr,
   output CellCfgType    lut_rdata
);

   CellCfgType mem [DEPTH];

   // Storage: whole table cleared on reset, otherwise single-entry write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read ports sample the array before any same-edge write lands (old data on collision).
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata <= '0;
         lut_rdata <= '0;
      end else begin
         if (cpu_re) cpu_rdata <= mem[cpu_raddr];
         lut_rdata <= mem[lut_raddr];
      end
   end

endmodule

// File: rtl/cpu_cfg_regs.sv
// CPU-accessible cell configuration table with a free-running datapath lookup port.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | waiting for a fresh decoded strobe, Rdy_Dtack high
//  ST_ACCESS | one cycle: bus request latched, commit/read at exit edge
//  ST_ACK    | Rdy_Dtack low until Sel rises or the latched strobe drops
module cpu_cfg_regs
   import data_pkg::*;
#(
   parameter int DEPTH = NUM_CFG,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   CPU_if.Peripheral                     cpu,
   input  logic [AW-1:0]                 lut_addr,
   output logic [$bits(CellCfgType)-1:0] lut_data
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ACK
   } state_t;

   localparam logic [12:0] DEPTH_L = 13'(DEPTH);

   state_t        state;
   logic [AW-1:0] addr_q;
   CellCfgType    data_q;
   logic          wr_q;
   logic          mode_q;
   logic          in_range_q;
   logic          rd_ack_q;
   logic          rdy_q;

   bus_req_t      req;
   logic          held;
   logic          addr_in_range;
   logic          mem_we;
   logic          mem_re;
   CellCfgType    cpu_rdata;
   CellCfgType    lut_rdata;

   assign req           = decode_req(cpu.BusMode, cpu.Sel, cpu.Rd_DS, cpu.Wr_RW);
   assign held          = strobe_held(mode_q, wr_q, cpu.Sel, cpu.Rd_DS, cpu.Wr_RW);
   assign addr_in_range = {1'b0, cpu.Addr} < DEPTH_L;

   // Out-of-range writes still run the full handshake but never touch storage.
   assign mem_we = (state == ST_ACCESS) && wr_q && in_range_q;
   assign mem_re = (state == ST_ACCESS);

   // Bus handshake FSM; everything the cycle needs is captured on the IDLE exit edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         wr_q       <= 1'b0;
         mode_q     <= 1'b0;
         in_range_q <= 1'b0;
         rd_ack_q   <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req.valid) begin
                  state      <= ST_ACCESS;
                  addr_q     <= cpu.Addr[AW-1:0];
                  data_q     <= cpu.DataIn;
                  wr_q       <= req.write;
                  mode_q     <= cpu.BusMode;
                  in_range_q <= addr_in_range;
               end
            end
            ST_ACCESS: begin
               state    <= ST_ACK;
               rdy_q    <= 1'b0;
               rd_ack_q <= !wr_q && in_range_q;
            end
            ST_ACK: begin
               if (!held) begin
                  state    <= ST_IDLE;
                  rdy_q    <= 1'b1;
                  rd_ack_q <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               rdy_q    <= 1'b1;
               rd_ack_q <= 1'b0;
            end
         endcase
      end
   end

   cfg_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_cfg_mem (
      .clk       (clk),
      .rst       (rst),
      .we        (mem_we),
      .waddr     (addr_q),
      .wdata     (data_q),
      .cpu_re    (mem_re),
      .cpu_raddr (addr_q),
      .cpu_rdata (cpu_rdata),
      .lut_raddr (lut_addr),
      .lut_rdata (lut_rdata)
   );

   // The read register only holds meaningful data during the ACK of an in-range read.
   assign cpu.DataOut   = rd_ack_q ? cpu_rdata : '0;
   assign cpu.Rdy_Dtack = rdy_q;
   assign lut_data      = lut_rdata;

endmodule

// File: tb/tb_cpu_cfg_regs.sv
// Scoreboard bench for cpu_cfg_regs: directed corner cases plus random bus traffic.
module tb_cpu_cfg_regs;
   import data_pkg::*;

   localparam int DEPTH = NUM_CFG;
   localparam int AW    = $clog2(DEPTH);

   typedef virtual CPU_if vCPU_T;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] lut_addr = '0;
   logic [15:0]   lut_data;

   CPU_if cpu_bus ();
   vCPU_T vcpu;

   cpu_cfg_regs #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu      (cpu_bus.Peripheral),
      .lut_addr (lut_addr),
      .lut_data (lut_data)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] model [DEPTH];
   logic [15:0] exp_q [$];
   logic        prev_rdy = 1'b1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rdy16();
      return {15'b0, cpu_bus.Rdy_Dtack};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0;
   endtask

   // Expected read value / model update, taken from the table rules alone.
   task automatic model_access(input bit wr, input logic [11:0] addr,
                               input logic [15:0] data, output logic [15:0] exp);
      exp = 16'h0;
      if (addr < DEPTH) begin
         if (wr) model[addr[AW-1:0]] = data;
         else    exp = model[addr[AW-1:0]];
      end
   endtask

   task automatic drive_strobe(input bit mode, input bit wr, input logic [11:0] addr,
                               input logic [15:0] data);
      vcpu.BusMode = mode;
      vcpu.Addr    = addr;
      vcpu.DataIn  = data;
      vcpu.Sel     = 1'b0;
      if (mode) begin
         vcpu.Rd_DS = wr;
         vcpu.Wr_RW = !wr;
      end else begin
         vcpu.Rd_DS = 1'b0;
         vcpu.Wr_RW = !wr;
      end
   endtask

   task automatic release_bus();
      vcpu.Sel   = 1'b1;
      vcpu.Rd_DS = 1'b1;
      vcpu.Wr_RW = 1'b1;
   endtask

   // One complete bus cycle; address/data are scrambled after the sample edge.
   task automatic xfer(input bit mode, input bit wr, input logic [11:0] addr,
                       input logic [15:0] data);
      logic [15:0] exp;
      model_access(wr, addr, data, exp);
      exp_q.push_back(exp);
      @(negedge clk);
      drive_strobe(mode, wr, addr, data);
      @(posedge clk); #1;
      check("rdy_in_access", rdy16(), 16'h1);
      vcpu.Addr   = 12'($urandom);
      vcpu.DataIn = 16'($urandom);
      @(posedge clk);
      @(posedge clk); #1;
      check("rdy_ack_latency", rdy16(), 16'h0);
      @(negedge clk);
      release_bus();
      @(posedge clk); #1;
      check("rdy_release", rdy16(), 16'h1);
   endtask

   task automatic lut_check(input logic [AW-1:0] a, input string name);
      @(negedge clk);
      lut_addr = a;
      @(posedge clk); #1;
      check(name, lut_data, model[a]);
   endtask

   // Monitor: every falling Rdy_Dtack retires one expected DataOut; DataOut must be 0 otherwise.
   always @(negedge clk) begin
      if (prev_rdy && !cpu_bus.Rdy_Dtack) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ack_unexpected actual=ack required=no_ack");
         end else begin
            check("dataout_ack", cpu_bus.DataOut, exp_q.pop_front());
         end
      end else if (cpu_bus.Rdy_Dtack) begin
         check("dataout_idle", cpu_bus.DataOut, 16'h0);
      end
      prev_rdy = cpu_bus.Rdy_Dtack;
   end

   initial begin
      logic [15:0] d;
      vcpu = cpu_bus;
      vcpu.BusMode = 1'b1;
      vcpu.Addr    = '0;
      vcpu.DataIn  = '0;
      release_bus();
      clear_model();

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdy", rdy16(), 16'h1);
      check("reset_dataout", cpu_bus.DataOut, 16'h0);
      check("reset_lut", lut_data, 16'h0);
      @(negedge clk);
      rst = 1'b0;

      // Mode 1 write then read, Mode 0 write then read
      xfer(1'b1, 1'b1, 12'h005, 16'hA123);
      xfer(1'b1, 1'b0, 12'h005, 16'h0000);
      xfer(1'b0, 1'b1, 12'h0FF, 16'h5FFF);
      xfer(1'b0, 1'b0, 12'h0FF, 16'h0000);

      // Out-of-range write/read
      xfer(1'b1, 1'b1, 12'h100, 16'h1234);
      xfer(1'b1, 1'b0, 12'h100, 16'h0000);
      lut_check(8'h00, "lut_entry0");
      lut_check(8'h05, "lut_entry5");

      // Collision between commit and lookup of entry 0x07
      @(negedge clk);
      lut_addr = 8'h07;
      exp_q.push_back(16'h0);
      drive_strobe(1'b1, 1'b1, 12'h007, 16'hBEEF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("lut_collision_old", lut_data, 16'h0000);
      @(posedge clk); #1;
      check("lut_collision_new", lut_data, 16'hBEEF);
      model[7] = 16'hBEEF;
      @(negedge clk);
      release_bus();
      @(posedge clk); #1;
      check("rdy_release_collision", rdy16(), 16'h1);

      // Held strobe: one access, Rdy_Dtack low until release
      exp_q.push_back(16'h0);
      model[8'h20] = 16'h1357;
      @(negedge clk);
      drive_strobe(1'b1, 1'b1, 12'h020, 16'h1357);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         vcpu.DataIn = 16'($urandom);
         if (k >= 2) check("rdy_held", rdy16(), 16'h0);
      end
      @(negedge clk);
      release_bus();
      @(posedge clk); #1;
      check("rdy_held_release", rdy16(), 16'h1);
      xfer(1'b1, 1'b0, 12'h020, 16'h0000);

      // Illegal Mode 1 strobe combination
      @(negedge clk);
      vcpu.BusMode = 1'b1;
      vcpu.Addr    = 12'h020;
      vcpu.DataIn  = 16'hDEAD;
      vcpu.Sel     = 1'b0;
      vcpu.Rd_DS   = 1'b0;
      vcpu.Wr_RW   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("rdy_illegal", rdy16(), 16'h1);
      end
      @(negedge clk);
      release_bus();
      xfer(1'b1, 1'b0, 12'h020, 16'h0000);

      // Reset during ACCESS of a write
      @(negedge clk);
      lut_addr = 8'h10;
      drive_strobe(1'b1, 1'b1, 12'h010, 16'h0F0F);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_access_rdy", rdy16(), 16'h1);
      check("rst_access_lut", lut_data, 16'h0);
      release_bus();
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      xfer(1'b1, 1'b0, 12'h010, 16'h0000);
      lut_check(8'h10, "lut_after_rst");
      lut_check(8'h05, "lut_cleared5");

      // Reset during ACK
      exp_q.push_back(16'h0);
      @(negedge clk);
      drive_strobe(1'b0, 1'b1, 12'h033, 16'h7777);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      check("ack_before_rst", rdy16(), 16'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_ack_rdy", rdy16(), 16'h1);
      release_bus();
      @(negedge clk);
      rst = 1'b0;
      clear_model();

      // Random traffic
      for (int n = 0; n < 60; n++) begin
         d = 16'($urandom);
         xfer(1'($urandom), 1'($urandom), 12'($urandom_range(0, 383)), d);
      end
      for (int n = 0; n < 30; n++) begin
         lut_check(AW'($urandom), "lut_random");
      end

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
